seq_comparator: RTL and testbench
=================================

SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits compared per clock; WIDTH SHALL be a multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1: single clock, rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1: request a compare; sampled only in IDLE.
REQ-006 SHALL have port a  input  WIDTH: operand A; captured on the accepting edge.
REQ-007 SHALL have port b  input  WIDTH: operand B; captured on the accepting edge.
REQ-008 SHALL have port is_signed  input  1: two's-complement compare when 1; captured with operands.
REQ-009 SHALL have port busy  output  1: compare in progress.
REQ-010 SHALL have port done  output  1: one-cycle pulse marking valid results.
REQ-011 SHALL have ports is_a_greater, is_a_less, equal  output  1 each: registered result flags.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after N chunk steps, DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL, on the edge accepting start (edge k), capture a, b, is_signed, clear chunk index and the decided flag, and raise busy.
REQ-014 SHALL compare chunks MSB-first, one per edge k+1..k+N, chunk index counting 0..N-1 and saturating, with no wrap.
REQ-015 SHALL, at the first chunk that differs, latch greater/less and set decided; later chunks SHALL NOT alter the latched decision.
REQ-016 SHALL, in signed mode, invert the top bit of both operands in the first (MSB) chunk only; other chunks are compared unsigned.
REQ-017 SHALL, at edge k+N, update is_a_greater/is_a_less/equal together; equal=1 iff no chunk differed; exactly one flag SHALL be 1.
REQ-018 SHALL hold busy=1 from edge k until edge k+N, and done=1 for exactly the cycle after edge k+N; latency is fixed at N edges regardless of early decision.
REQ-019 SHALL hold result flags stable from edge k+N until the next accepted start's edge k+N; intermediate chunk steps SHALL NOT appear on the outputs.
REQ-020 SHALL ignore start while in RUN or DONE; start held high during DONE SHALL be accepted on the first IDLE edge.
REQ-021 SHALL ignore changes on a, b and is_signed after capture.

Reset
REQ-022 SHALL, on reset assertion, immediately enter IDLE and drive busy=0, done=0, is_a_greater=0, is_a_less=0, equal=0, chunk index=0, independent of clk.
REQ-023 SHALL abort an in-progress compare on reset with no done pulse, and accept start on the first edge after reset deasserts.

Configuration
REQ-024 SHALL support signed compare only when macro SEQ_COMPARATOR_SIGNED_EN is defined; REQ-016 then applies.
REQ-025 SHALL, without SEQ_COMPARATOR_SIGNED_EN, keep the is_signed port, ignore it, and always compare unsigned.

Verification (WIDTH=16, CHUNK=4, N=4, SEQ_COMPARATOR_SIGNED_EN defined unless noted)
REQ-026 SHALL check: reset, then start, a=0x1234, b=0x1234 -> busy for 4 cycles, done pulse 4 edges after accept, equal=1, greater=0, less=0.
REQ-027 SHALL check: a=0x8000, b=0x7FFF, is_signed=0 -> greater=1; same operands with is_signed=1 -> less=1; with macro undefined and is_signed=1 -> greater=1.
REQ-028 SHALL check: a=0xA000, b=0x9FFF unsigned (decided at chunk 0) -> greater=1 with the same 4-edge latency as the equal case.
REQ-029 SHALL check: start pulsed in every cycle during RUN and DONE with new operands -> only the first compare runs; start held high through DONE is accepted on the next IDLE edge.
REQ-030 SHALL check: reset asserted asynchronously at chunk 2 of a compare -> all outputs go to 0 before the next clk edge, no done pulse, and the next compare (a=0x0001, b=0x0002) yields less=1.

Source files
------------

// File: rtl/seq_comparator.sv
// Sequential magnitude comparator: compares a and b CHUNK bits per clock, MSB chunk first.
// Define SEQ_COMPARATOR_SIGNED_EN to honour is_signed (two's-complement); otherwise always unsigned.
module seq_comparator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             is_a_greater,
    output logic             is_a_less,
    output logic             equal
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [IDX_W-1:0] idx;
    logic             decided;
    logic             dec_gt;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             sign_flip;
    logic             chunk_gt;
    logic             chunk_lt;

`ifdef SEQ_COMPARATOR_SIGNED_EN
    logic signed_q;
    assign sign_flip = signed_q && (idx == IDX_W'(0));
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign sign_flip        = 1'b0;
`endif

    // Current chunk sits at the top of the shift registers; signed mode biases the sign bit.
    always_comb begin
        chunk_a = a_sh[WIDTH-1 -: CHUNK];
        chunk_b = b_sh[WIDTH-1 -: CHUNK];
        if (sign_flip) begin
            chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
            chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
        end
        chunk_gt = (chunk_a > chunk_b);
        chunk_lt = (chunk_a < chunk_b);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            a_sh         <= '0;
            b_sh         <= '0;
            idx          <= '0;
            decided      <= 1'b0;
            dec_gt       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            is_a_greater <= 1'b0;
            is_a_less    <= 1'b0;
            equal        <= 1'b0;
`ifdef SEQ_COMPARATOR_SIGNED_EN
            signed_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        a_sh    <= a;
                        b_sh    <= b;
                        idx     <= '0;
                        decided <= 1'b0;
                        dec_gt  <= 1'b0;
                        busy    <= 1'b1;
`ifdef SEQ_COMPARATOR_SIGNED_EN
                        signed_q <= is_signed;
`endif
                    end
                end
                RUN: begin
                    a_sh <= a_sh << CHUNK;
                    b_sh <= b_sh << CHUNK;
                    // First differing chunk wins; later chunks cannot overturn it.
                    if (!decided && (chunk_gt || chunk_lt)) begin
                        decided <= 1'b1;
                        dec_gt  <= chunk_gt;
                    end
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (decided) begin
                            is_a_greater <= dec_gt;
                            is_a_less    <= ~dec_gt;
                            equal        <= 1'b0;
                        end else begin
                            is_a_greater <= chunk_gt;
                            is_a_less    <= chunk_lt;
                            equal        <= ~(chunk_gt | chunk_lt);
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_comparator.sv
// Directed self-checking bench for seq_comparator at WIDTH=16, CHUNK=4 (four chunk steps).
// Signed expectations follow whether SEQ_COMPARATOR_SIGNED_EN is defined for the build.
module tb_seq_comparator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic        is_a_greater;
    logic        is_a_less;
    logic        equal;
    logic [2:0]  flags;
    logic [2:0]  prev_flags;

    int unsigned errors = 0;
    int unsigned checks = 0;

    assign flags = {is_a_greater, is_a_less, equal};

    always #5 clk = ~clk;

    seq_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .a            (a),
        .b            (b),
        .is_signed    (is_signed),
        .busy         (busy),
        .done         (done),
        .is_a_greater (is_a_greater),
        .is_a_less    (is_a_less),
        .equal        (equal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full compare; inputs are scrambled after capture, and timing of busy/done is checked each cycle.
    task automatic run_cmp(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic vs, input logic [2:0] exp_flags);
        @(negedge clk);
        start = 1'b1; a = va; b = vb; is_signed = vs;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb; is_signed = ~vs;
        chk({tag, " busy@k"}, 32'(busy), 32'd1);
        chk({tag, " done@k"}, 32'(done), 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk({tag, " busy@run"}, 32'(busy), 32'd1);
            chk({tag, " done@run"}, 32'(done), 32'd0);
            chk({tag, " flags held@run"}, 32'(flags), 32'(prev_flags));
        end
        @(negedge clk);
        chk({tag, " busy@k+N"}, 32'(busy), 32'd0);
        chk({tag, " done@k+N"}, 32'(done), 32'd1);
        chk({tag, " flags"}, 32'(flags), 32'(exp_flags));
        @(negedge clk);
        chk({tag, " done pulse end"}, 32'(done), 32'd0);
        chk({tag, " flags stable"}, 32'(flags), 32'(exp_flags));
        prev_flags = exp_flags;
    endtask

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    initial begin
        logic [2:0] signed_exp;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        prev_flags = 3'b000;
        #2;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset flags", 32'(flags), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_cmp("eq 1234", 16'h1234, 16'h1234, 1'b0, EQ);
        run_cmp("u 8000>7FFF", 16'h8000, 16'h7FFF, 1'b0, GT);
`ifdef SEQ_COMPARATOR_SIGNED_EN
        signed_exp = LT;
`else
        signed_exp = GT;
`endif
        run_cmp("s 8000 vs 7FFF", 16'h8000, 16'h7FFF, 1'b1, signed_exp);
        run_cmp("u A000>9FFF", 16'hA000, 16'h9FFF, 1'b0, GT);
        run_cmp("s FFFE<FFFF", 16'hFFFE, 16'hFFFF, 1'b1, LT);
        run_cmp("u 1F00<20FF latch", 16'h1F00, 16'h20FF, 1'b0, LT);
        run_cmp("u 0000<0001 last", 16'h0000, 16'h0001, 1'b0, LT);

        // Start pulsed throughout RUN and held through DONE: second request waits for IDLE.
        @(negedge clk);
        start = 1'b1; a = 16'h0005; b = 16'h0003; is_signed = 1'b0;
        @(negedge clk);
        a = 16'h0010; b = 16'h0100;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("st ignore busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("st first done", 32'(done), 32'd1);
        chk("st first flags", 32'(flags), 32'(GT));
        @(negedge clk);
        chk("st idle busy", 32'(busy), 32'd0);
        chk("st idle done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("st second accepted", 32'(busy), 32'd1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("st second busy", 32'(busy), 32'd1);
            chk("st flags held", 32'(flags), 32'(GT));
        end
        @(negedge clk);
        chk("st second done", 32'(done), 32'd1);
        chk("st second flags", 32'(flags), 32'(LT));
        prev_flags = LT;

        // Asynchronous reset mid-compare at chunk 2.
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ar busy before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("ar busy", 32'(busy), 32'd0);
        chk("ar done", 32'(done), 32'd0);
        chk("ar flags", 32'(flags), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ar no done", 32'(done), 32'd0);
            chk("ar idle busy", 32'(busy), 32'd0);
        end
        prev_flags = 3'b000;
        run_cmp("after reset 0001<0002", 16'h0001, 16'h0002, 1'b0, LT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
